// File: rtl/bfm_ahbl_pkg.sv
// rtl/bfm_ahbl_pkg.sv - shared AHB-Lite codes, responder states and byte-lane helper
package bfm_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } ahbl_state_e;

    // Byte lanes touched by a transfer; only called for legal (aligned, <= word) sizes.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr;
            HSIZE_HALF: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/bfm_ahbl_lane_ram.sv
// rtl/bfm_ahbl_lane_ram.sv - 32-bit word RAM, per-byte synchronous write, asynchronous read
module bfm_ahbl_lane_ram #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/bfm_ahbl_slave_mem.sv
// rtl/bfm_ahbl_slave_mem.sv - AHB-Lite responder memory with wait states and an error window
module bfm_ahbl_slave_mem
    import bfm_ahbl_pkg::*;
#(
    parameter int          MEM_AW      = 10,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ERR_BASE    = 32'hFFFF_F000,
    parameter logic [31:0] ERR_SIZE    = 32'h0000_1000,
    parameter int          TPD         = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic        HMASTLOCK,
    input  logic [3:0]  HPROT,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [15:0] WR_COUNT,
    output logic [15:0] RD_COUNT
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);
    localparam int unused_tpd = TPD;

    ahbl_state_e       state;
    logic [3:0]        cnt;
    logic              dp_valid;
    logic              dp_write;
    logic [MEM_AW-1:0] dp_idx;
    logic [3:0]        dp_be;
    logic [31:0]       ram_rdata;

    logic accept;
    logic in_window;
    logic misaligned;
    logic addr_err;
    logic complete;
    logic unused_ok;

    assign unused_ok = ^{HBURST, HMASTLOCK, HPROT};

    assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
    assign HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

    // Subtracting before comparing keeps a window that ends at 4 GiB from wrapping.
    assign in_window  = (ERR_SIZE != 32'd0) && (HADDR >= ERR_BASE) && ((HADDR - ERR_BASE) < ERR_SIZE);
    assign misaligned = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                        ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign addr_err   = in_window || (HSIZE > HSIZE_WORD) || misaligned;

    assign accept   = HSEL && HREADYIN && HREADYOUT &&
                      ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    assign complete = (state == ST_IDLE) && dp_valid;
    assign HRDATA   = (complete && !dp_write) ? ram_rdata : 32'h0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_be    <= 4'd0;
            WR_COUNT <= 16'd0;
            RD_COUNT <= 16'd0;
        end else begin
            if (complete) begin
                dp_valid <= 1'b0;
                if (dp_write) WR_COUNT <= WR_COUNT + 16'd1;
                else          RD_COUNT <= RD_COUNT + 16'd1;
            end
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd1) begin
                        state    <= ST_IDLE;
                        dp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                ST_ERR2: state <= ST_IDLE;
                default: ;
            endcase
            // A new address phase overrides the default next state, so pipelining falls out naturally.
            if (accept) begin
                dp_write <= HWRITE;
                dp_idx   <= HADDR[MEM_AW+1:2];
                dp_be    <= lane_mask(HSIZE, HADDR[1:0]);
                if (addr_err) begin
                    state <= ST_ERR1;
                end else if (WS != 4'd0) begin
                    state <= ST_WAIT;
                    cnt   <= WS;
                end else begin
                    state    <= ST_IDLE;
                    dp_valid <= 1'b1;
                end
            end
        end
    end

    bfm_ahbl_lane_ram #(
        .AW(MEM_AW)
    ) u_ram (
        .clk   (HCLK),
        .we    (complete && dp_write),
        .idx   (dp_idx),
        .be    (dp_be),
        .wdata (HWDATA),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_bfm_ahbl_slave_mem.sv
// tb/tb_bfm_ahbl_slave_mem.sv - self-checking bench for bfm_ahbl_slave_mem
module tb_bfm_ahbl_slave_mem;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [2:0]  hsel = 3'b000;
    logic [31:0] haddr = 32'h0;
    logic [31:0] hwdata = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic        force_nready = 1'b0;

    logic        hreadyout [3];
    logic        hresp [3];
    logic        hreadyin [3];
    logic [31:0] hrdata [3];
    logic [15:0] wr_cnt [3];
    logic [15:0] rd_cnt [3];

    int n_checks = 0;
    int n_fail = 0;
    int exp_wr [3] = '{0, 0, 0};
    int exp_rd [3] = '{0, 0, 0};
    logic [31:0] exp_q [$];

    always #5 HCLK = ~HCLK;

    assign hreadyin[0] = !force_nready && hreadyout[0];
    assign hreadyin[1] = !force_nready && hreadyout[1];
    assign hreadyin[2] = !force_nready && hreadyout[2];

    bfm_ahbl_slave_mem #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HMASTLOCK(1'b0), .HPROT(4'b0011),
        .HWDATA(hwdata), .HREADYIN(hreadyin[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]),
        .HRDATA(hrdata[0]), .WR_COUNT(wr_cnt[0]), .RD_COUNT(rd_cnt[0])
    );

    bfm_ahbl_slave_mem #(.WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HMASTLOCK(1'b0), .HPROT(4'b0011),
        .HWDATA(hwdata), .HREADYIN(hreadyin[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]),
        .HRDATA(hrdata[1]), .WR_COUNT(wr_cnt[1]), .RD_COUNT(rd_cnt[1])
    );

    bfm_ahbl_slave_mem #(.WAIT_STATES(2)) u_ws2 (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HMASTLOCK(1'b0), .HPROT(4'b0011),
        .HWDATA(hwdata), .HREADYIN(hreadyin[2]), .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]),
        .HRDATA(hrdata[2]), .WR_COUNT(wr_cnt[2]), .RD_COUNT(rd_cnt[2])
    );

    // One non-pipelined transfer; entered and left 1 ns after a rising edge.
    task automatic single(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, output int lows, output bit low_resp,
                          output bit done_resp, output logic [31:0] rdata);
        bit done = 1'b0;
        hsel[d] = 1'b1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz;
        @(posedge HCLK); #1;
        hsel[d] = 1'b0; htrans = 2'b00; hwdata = wd;
        lows = 0; low_resp = 1'b0; done_resp = 1'b0; rdata = 32'h0;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge HCLK);
            if (hreadyout[d]) begin
                done = 1'b1; done_resp = hresp[d]; rdata = hrdata[d];
            end else begin
                lows++; low_resp = low_resp | hresp[d];
            end
            @(posedge HCLK); #1;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL xfer_timeout dut%0d addr %h: got no HREADYOUT, expected completion", d, a); end
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;
        @(negedge HCLK);
        for (int d = 0; d < 3; d++) begin
            n_checks++; if (hreadyout[d] !== 1'b1) begin n_fail++; $display("FAIL reset_hready dut%0d: got %b expected 1", d, hreadyout[d]); end
            n_checks++; if (hresp[d] !== 1'b0) begin n_fail++; $display("FAIL reset_hresp dut%0d: got %b expected 0", d, hresp[d]); end
            n_checks++; if (hrdata[d] !== 32'h0) begin n_fail++; $display("FAIL reset_hrdata dut%0d: got %h expected 0", d, hrdata[d]); end
            n_checks++; if (wr_cnt[d] !== 16'd0 || rd_cnt[d] !== 16'd0) begin n_fail++; $display("FAIL reset_counts dut%0d: got %0d/%0d expected 0/0", d, wr_cnt[d], rd_cnt[d]); end
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        hsel[0] = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hwrite = 1'b0; hwdata = 32'h1234_5678;
        exp_q.push_back(32'h1234_5678);
        @(negedge HCLK);
        n_checks++; if (hreadyout[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_ready: got %b expected 1", hreadyout[0]); end
        n_checks++; if (hrdata[0] !== 32'h0) begin n_fail++; $display("FAIL b2b_wr_hrdata: got %h expected 0", hrdata[0]); end
        @(posedge HCLK); #1;
        hsel[0] = 1'b0; htrans = 2'b00; exp_wr[0]++;
        @(negedge HCLK);
        exp = exp_q.pop_front();
        n_checks++; if (hreadyout[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_ready: got %b expected 1", hreadyout[0]); end
        n_checks++; if (hrdata[0] !== exp) begin n_fail++; $display("FAIL b2b_rd_data: got %h expected %h", hrdata[0], exp); end
        @(posedge HCLK); #1;
        exp_rd[0]++;
        n_checks++; if (wr_cnt[0] !== 16'(exp_wr[0])) begin n_fail++; $display("FAIL b2b_wr_count: got %0d expected %0d", wr_cnt[0], exp_wr[0]); end
        n_checks++; if (rd_cnt[0] !== 16'(exp_rd[0])) begin n_fail++; $display("FAIL b2b_rd_count: got %0d expected %0d", rd_cnt[0], exp_rd[0]); end
    endtask

    task automatic test_wait_states();
        int lows; bit lr, dr; logic [31:0] rd, exp;
        single(1, 1'b1, 32'h20, 3'd2, 32'hCAFE_0020, lows, lr, dr, rd); exp_wr[1]++;
        n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL ws3_wr_lows: got %0d expected 3", lows); end
        exp_q.push_back(32'hCAFE_0020);
        single(1, 1'b0, 32'h20, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[1]++;
        exp = exp_q.pop_front();
        n_checks++; if (lows !== 3) begin n_fail++; $display("FAIL ws3_rd_lows: got %0d expected 3", lows); end
        n_checks++; if (lr !== 1'b0 || dr !== 1'b0) begin n_fail++; $display("FAIL ws3_rd_resp: got %b/%b expected 0/0", lr, dr); end
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL ws3_rd_data: got %h expected %h", rd, exp); end
        n_checks++; if (wr_cnt[1] !== 16'(exp_wr[1]) || rd_cnt[1] !== 16'(exp_rd[1])) begin n_fail++; $display("FAIL ws3_counts: got %0d/%0d expected %0d/%0d", wr_cnt[1], rd_cnt[1], exp_wr[1], exp_rd[1]); end
    endtask

    task automatic test_byte_lanes();
        int lows; bit lr, dr; logic [31:0] rd, exp;
        single(0, 1'b1, 32'h40, 3'd2, 32'h0, lows, lr, dr, rd); exp_wr[0]++;
        single(0, 1'b1, 32'h41, 3'd0, 32'h1122_AB33, lows, lr, dr, rd); exp_wr[0]++;
        exp_q.push_back(32'h0000_AB00);
        single(0, 1'b0, 32'h40, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[0]++;
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL byte_write: got %h expected %h", rd, exp); end
        single(0, 1'b1, 32'h42, 3'd1, 32'hBEEF_5566, lows, lr, dr, rd); exp_wr[0]++;
        exp_q.push_back(32'hBEEF_AB00);
        single(0, 1'b0, 32'h40, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[0]++;
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL half_write: got %h expected %h", rd, exp); end
        exp_q.push_back(32'hBEEF_AB00);
        single(0, 1'b0, 32'h1040, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[0]++;
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL addr_alias: got %h expected %h", rd, exp); end
        n_checks++; if (wr_cnt[0] !== 16'(exp_wr[0]) || rd_cnt[0] !== 16'(exp_rd[0])) begin n_fail++; $display("FAIL lane_counts: got %0d/%0d expected %0d/%0d", wr_cnt[0], rd_cnt[0], exp_wr[0], exp_rd[0]); end
    endtask

    task automatic test_error();
        int lows; bit lr, dr; logic [31:0] rd, exp;
        single(0, 1'b1, 32'h4, 3'd2, 32'h5A5A_5A5A, lows, lr, dr, rd); exp_wr[0]++;
        single(0, 1'b1, 32'hFFFF_F004, 3'd2, 32'hDEAD_BEEF, lows, lr, dr, rd);
        n_checks++; if (lows !== 1 || lr !== 1'b1) begin n_fail++; $display("FAIL err1_phase: got lows %0d resp %b expected 1/1", lows, lr); end
        n_checks++; if (dr !== 1'b1) begin n_fail++; $display("FAIL err2_phase: got resp %b expected 1", dr); end
        n_checks++; if (wr_cnt[0] !== 16'(exp_wr[0])) begin n_fail++; $display("FAIL err_wr_count: got %0d expected %0d", wr_cnt[0], exp_wr[0]); end
        exp_q.push_back(32'h5A5A_5A5A);
        single(0, 1'b0, 32'h4, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[0]++;
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp || dr !== 1'b0 || lows !== 0) begin n_fail++; $display("FAIL err_follow_read: got %h resp %b lows %0d expected %h/0/0", rd, dr, lows, exp); end
        single(0, 1'b0, 32'h2, 3'd2, 32'h0, lows, lr, dr, rd);
        n_checks++; if (lows !== 1 || lr !== 1'b1 || dr !== 1'b1) begin n_fail++; $display("FAIL misaligned_err: got lows %0d resp %b/%b expected 1 1/1", lows, lr, dr); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_hrdata: got %h expected 0", rd); end
        n_checks++; if (rd_cnt[0] !== 16'(exp_rd[0])) begin n_fail++; $display("FAIL err_rd_count: got %0d expected %0d", rd_cnt[0], exp_rd[0]); end
    endtask

    task automatic test_ignored();
        int lows; bit lr, dr; logic [31:0] rd, exp;
        single(0, 1'b1, 32'h80, 3'd2, 32'h0000_0077, lows, lr, dr, rd); exp_wr[0]++;
        hsel[0] = 1'b1; htrans = 2'b10; haddr = 32'h80; hwrite = 1'b1; hsize = 3'd2; force_nready = 1'b1;
        @(posedge HCLK); #1;
        force_nready = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        @(negedge HCLK);
        n_checks++; if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0) begin n_fail++; $display("FAIL nready_ignored: got %b/%b expected 1/0", hreadyout[0], hresp[0]); end
        @(posedge HCLK); #1;
        htrans = 2'b01;
        @(negedge HCLK);
        n_checks++; if (hreadyout[0] !== 1'b1 || hresp[0] !== 1'b0) begin n_fail++; $display("FAIL idle_ignored: got %b/%b expected 1/0", hreadyout[0], hresp[0]); end
        @(posedge HCLK); #1;
        hsel[0] = 1'b0; htrans = 2'b00;
        @(negedge HCLK);
        n_checks++; if (hreadyout[0] !== 1'b1 || hrdata[0] !== 32'h0) begin n_fail++; $display("FAIL busy_ignored: got %b/%h expected 1/0", hreadyout[0], hrdata[0]); end
        n_checks++; if (wr_cnt[0] !== 16'(exp_wr[0]) || rd_cnt[0] !== 16'(exp_rd[0])) begin n_fail++; $display("FAIL ignored_counts: got %0d/%0d expected %0d/%0d", wr_cnt[0], rd_cnt[0], exp_wr[0], exp_rd[0]); end
        @(posedge HCLK); #1;
        exp_q.push_back(32'h0000_0077);
        single(0, 1'b0, 32'h80, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[0]++;
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL ignored_mem: got %h expected %h", rd, exp); end
    endtask

    task automatic test_reset_mid();
        int lows; bit lr, dr; logic [31:0] rd, exp;
        single(2, 1'b1, 32'h100, 3'd2, 32'h1357_9BDF, lows, lr, dr, rd);
        n_checks++; if (lows !== 2) begin n_fail++; $display("FAIL ws2_wr_lows: got %0d expected 2", lows); end
        hsel[2] = 1'b1; htrans = 2'b10; haddr = 32'h100; hwrite = 1'b1; hsize = 3'd2;
        @(posedge HCLK); #1;
        hsel[2] = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
        @(negedge HCLK);
        n_checks++; if (hreadyout[2] !== 1'b0) begin n_fail++; $display("FAIL ws2_in_wait: got %b expected 0", hreadyout[2]); end
        @(posedge HCLK); #1 HRESET = 1'b1;
        @(posedge HCLK); #1 HRESET = 1'b0;
        for (int d = 0; d < 3; d++) begin exp_wr[d] = 0; exp_rd[d] = 0; end
        @(negedge HCLK);
        n_checks++; if (hreadyout[2] !== 1'b1 || hresp[2] !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got %b/%b expected 1/0", hreadyout[2], hresp[2]); end
        n_checks++; if (wr_cnt[2] !== 16'd0) begin n_fail++; $display("FAIL midreset_wr_count: got %0d expected 0", wr_cnt[2]); end
        repeat (3) @(posedge HCLK);
        #1;
        n_checks++; if (wr_cnt[2] !== 16'd0) begin n_fail++; $display("FAIL midreset_no_commit: got %0d expected 0", wr_cnt[2]); end
        exp_q.push_back(32'h1357_9BDF);
        single(2, 1'b0, 32'h100, 3'd2, 32'h0, lows, lr, dr, rd); exp_rd[2]++;
        exp = exp_q.pop_front();
        n_checks++; if (rd !== exp) begin n_fail++; $display("FAIL midreset_mem: got %h expected %h", rd, exp); end
        n_checks++; if (rd_cnt[2] !== 16'(exp_rd[2]) || wr_cnt[2] !== 16'd0) begin n_fail++; $display("FAIL midreset_counts: got %0d/%0d expected 0/%0d", wr_cnt[2], rd_cnt[2], exp_rd[2]); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_byte_lanes();
        test_error();
        test_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
